// File: rtl/preif_fetch_pcgen_if.sv
// Bundle of the PreIF stage's redirect, instruction-SRAM request and
// IF-stage hand-off signals. The master modport is the PC generator side.
`timescale 1ns/1ps

interface preif_fetch_pcgen_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned FETCH_N = 2,
   parameter int unsigned NRED    = 4
);
   logic [NRED-1:0]      redirect_valid_i;
   logic [NRED*PC_W-1:0] redirect_pc_i;
   logic                 flush_i;
   logic                 cpu_error_i;
   logic                 interrupt_en_i;
   logic                 next_allowin_i;
   logic                 inst_sram_req_o;
   logic [PC_W-1:0]      inst_sram_addr_o;
   logic                 inst_sram_addr_ok_i;
   logic                 inst_sram_data_ok_i;
   logic                 to_next_valid_o;
   logic [PC_W-1:0]      to_next_pc_o;
   logic [FETCH_N-1:0]   to_next_mask_o;
   logic                 to_next_int_o;
   logic                 to_next_adef_o;

   modport master (
      input  redirect_valid_i, redirect_pc_i, flush_i, cpu_error_i,
             interrupt_en_i, next_allowin_i, inst_sram_addr_ok_i,
             inst_sram_data_ok_i,
      output inst_sram_req_o, inst_sram_addr_o, to_next_valid_o,
             to_next_pc_o, to_next_mask_o, to_next_int_o, to_next_adef_o
   );

   modport slave (
      output redirect_valid_i, redirect_pc_i, flush_i, cpu_error_i,
             interrupt_en_i, next_allowin_i, inst_sram_addr_ok_i,
             inst_sram_data_ok_i,
      input  inst_sram_req_o, inst_sram_addr_o, to_next_valid_o,
             to_next_pc_o, to_next_mask_o, to_next_int_o, to_next_adef_o
   );
endinterface

// File: rtl/preif_fetch_pcgen.sv
// PreIF next-PC generator: picks the fetch PC from prioritised redirects or
// the sequential group address, issues the instruction-SRAM request, limits
// outstanding fetches and hands masked fetch groups to the IF stage.
`timescale 1ns/1ps

module preif_fetch_pcgen #(
   parameter int unsigned     PC_W      = 32,
   parameter int unsigned     FETCH_N   = 2,
   parameter int unsigned     NRED      = 4,
   parameter int unsigned     MAX_OUTST = 4,
   parameter logic [PC_W-1:0] RESET_PC  = 32'h1c000000
) (
   input logic                clk,
   input logic                rst_n,
   preif_fetch_pcgen_if.master bus
);
   localparam int unsigned     OW      = $clog2(MAX_OUTST + 1);
   localparam int unsigned     LW      = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;
   localparam logic [PC_W-1:0] GROUP_B = PC_W'(FETCH_N * 4);

   typedef enum logic [1:0] {RUN = 2'd0, EXC_HOLD = 2'd1, HALT = 2'd2} state_t;

   state_t             st_r, st_nxt;
   logic [PC_W-1:0]    pc_r, pc_nxt, sel_pc;
   logic [OW-1:0]      outst_r, outst_nxt;
   logic               redir, adef, exc, can_go, req, fire, inc, dec;
   logic [FETCH_N-1:0] mask;

   // Lowest-index valid redirect wins; otherwise continue from pc_r.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel_pc = pc_r;
      for (int k = NRED - 1; k >= 0; k--) begin
         if (bus.redirect_valid_i[k]) sel_pc = bus.redirect_pc_i[k*PC_W +: PC_W];
      end
   end

   assign redir  = |bus.redirect_valid_i;
   assign adef   = |sel_pc[1:0];
   assign exc    = adef | bus.interrupt_en_i;
   // A group may leave this cycle unless halted, stalled, flushed, or parked
   // in EXC_HOLD without a fresh redirect.
   assign can_go = rst_n & ((st_r == RUN) | redir) & (st_r != HALT) & ~bus.cpu_error_i
                 & bus.next_allowin_i & ~bus.flush_i;
   assign req    = can_go & ~exc & (outst_r < OW'(MAX_OUTST));
   // Exceptions bypass the SRAM: the group is tagged and handed on directly.
   assign fire   = (req & bus.inst_sram_addr_ok_i) | (exc & can_go);
   assign inc    = req & bus.inst_sram_addr_ok_i;
   assign dec    = bus.inst_sram_data_ok_i & (outst_r != '0);

   generate
      if (FETCH_N == 1) begin : g_mask_one
         assign mask = 1'b1;
      end else begin : g_mask_multi
         logic [LW-1:0] off;
         assign off = sel_pc[LW+1:2];
         // Lanes before the entry offset inside the group are invalid.
         always_comb begin
            for (int i = 0; i < FETCH_N; i++) mask[i] = (i >= int'(off));
         end
      end
   endgenerate

   // Next-state: PC advance, FSM transitions and outstanding-count update.
   always_comb begin
      pc_nxt = sel_pc;
      if (fire && !exc) pc_nxt = (sel_pc & ~(GROUP_B - PC_W'(1))) + GROUP_B;

      st_nxt = st_r;
      if (bus.cpu_error_i) begin
         st_nxt = HALT;
      end else if (st_r != HALT) begin
         if (fire && exc) st_nxt = EXC_HOLD;
         else if (redir)  st_nxt = RUN;
      end

      outst_nxt = outst_r;
      case ({inc, dec})
         2'b10:   outst_nxt = outst_r + OW'(1);
         2'b01:   outst_nxt = outst_r - OW'(1);
         default: outst_nxt = outst_r;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         pc_r    <= RESET_PC;
         outst_r <= '0;
         st_r    <= RUN;
      end else begin
         pc_r    <= pc_nxt;
         outst_r <= outst_nxt;
         st_r    <= st_nxt;
      end
   end

   assign bus.inst_sram_req_o  = req;
   assign bus.inst_sram_addr_o = rst_n ? sel_pc : RESET_PC;
   assign bus.to_next_pc_o     = rst_n ? sel_pc : RESET_PC;
   assign bus.to_next_valid_o  = fire;
   assign bus.to_next_mask_o   = rst_n ? mask : '0;
   assign bus.to_next_int_o    = bus.interrupt_en_i & fire;
   assign bus.to_next_adef_o   = adef & fire;
endmodule

// File: tb/tb_preif_fetch_pcgen.sv
// Self-checking bench for preif_fetch_pcgen: a directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a
// behavioural model built from the fetch rules.
`timescale 1ns/1ps

module tb_preif_fetch_pcgen;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned FETCH_N   = 2;
   localparam int unsigned NRED      = 4;
   localparam int unsigned MAX_OUTST = 4;
   localparam logic [31:0] RESET_PC  = 32'h1c000000;
   localparam int unsigned GROUP_B   = FETCH_N * 4;
   localparam int          NVEC      = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   preif_fetch_pcgen_if #(.PC_W(PC_W), .FETCH_N(FETCH_N), .NRED(NRED)) bus ();

   preif_fetch_pcgen #(
      .PC_W(PC_W), .FETCH_N(FETCH_N), .NRED(NRED),
      .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic               req;
      logic [31:0]        addr;
      logic               valid;
      logic [FETCH_N-1:0] mask;
      logic               intr;
      logic               adef;
   } out_t;

   typedef struct {
      logic [NRED-1:0]    rv;
      logic [NRED*32-1:0] rpc;
      logic               fl, intr, al, aok, dok;
      out_t               exp;
   } vec_t;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state: next fetch PC, fetches in flight, and whether
   // the stage waits for a redirect after an exception or is dead.
   logic [31:0] m_pc;
   int          m_outst;
   bit          m_hold, m_halt;

   vec_t tbl[NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_pc    = RESET_PC;
      m_outst = 0;
      m_hold  = 1'b0;
      m_halt  = 1'b0;
   endfunction

   function automatic void model_calc(output out_t o, output logic [31:0] npc, output int nout,
                                      output bit nhold, output bit nhalt);
      logic [31:0] sel;
      bit redir, adef, exc, can, fire, inc, dec;
      int off;
      sel   = m_pc;
      redir = 1'b0;
      for (int k = 0; k < NRED; k++) begin
         if (bus.redirect_valid_i[k]) begin
            sel   = bus.redirect_pc_i[k*32 +: 32];
            redir = 1'b1;
            break;
         end
      end
      adef   = (sel % 4) != 0;
      exc    = adef || bus.interrupt_en_i;
      can    = !m_halt && !bus.cpu_error_i && bus.next_allowin_i && !bus.flush_i
               && (!m_hold || redir);
      o.req  = can && !exc && (m_outst < MAX_OUTST);
      inc    = o.req && bus.inst_sram_addr_ok_i;
      fire   = inc || (exc && can);
      off    = (sel / 4) % FETCH_N;
      o.addr  = sel;
      o.valid = fire;
      o.mask  = FETCH_N'((1 << FETCH_N) - (1 << off));
      o.intr  = bus.interrupt_en_i && fire;
      o.adef  = adef && fire;
      npc   = (fire && !exc) ? 32'((longint'(sel) / GROUP_B) * GROUP_B + GROUP_B) : sel;
      dec   = bus.inst_sram_data_ok_i && (m_outst > 0);
      nout  = m_outst + int'(inc) - int'(dec);
      nhalt = m_halt || bus.cpu_error_i;
      nhold = m_hold;
      if (fire && exc) nhold = 1'b1;
      else if (redir)  nhold = 1'b0;
   endfunction

   task automatic check_model();
      out_t o;
      logic [31:0] npc;
      int nout;
      bit nh, nhl;
      if (!rst_n) o = '{req: 1'b0, addr: RESET_PC, valid: 1'b0, mask: '0, intr: 1'b0, adef: 1'b0};
      else model_calc(o, npc, nout, nh, nhl);
      check("m_req",   bus.inst_sram_req_o,  o.req);
      check("m_addr",  bus.inst_sram_addr_o, o.addr);
      check("m_pc",    bus.to_next_pc_o,     o.addr);
      check("m_valid", bus.to_next_valid_o,  o.valid);
      check("m_mask",  bus.to_next_mask_o,   o.mask);
      check("m_int",   bus.to_next_int_o,    o.intr);
      check("m_adef",  bus.to_next_adef_o,   o.adef);
   endtask

   task automatic settle();
      #4;
      check_model();
   endtask

   task automatic advance();
      out_t o;
      logic [31:0] npc;
      int nout;
      bit nh, nhl;
      @(posedge clk);
      assert (!(rst_n && bus.inst_sram_data_ok_i && m_outst == 0))
         else $error("data_ok driven with nothing outstanding");
      if (!rst_n) begin
         model_reset();
      end else begin
         model_calc(o, npc, nout, nh, nhl);
         m_pc = npc; m_outst = nout; m_hold = nh; m_halt = nhl;
      end
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic drive(input logic [NRED-1:0] rv, input logic [NRED*32-1:0] rpc,
                        input logic fl, input logic intr, input logic al,
                        input logic aok, input logic dok, input logic err = 1'b0);
      bus.redirect_valid_i    = rv;
      bus.redirect_pc_i       = rpc;
      bus.flush_i             = fl;
      bus.interrupt_en_i      = intr;
      bus.next_allowin_i      = al;
      bus.inst_sram_addr_ok_i = aok;
      bus.inst_sram_data_ok_i = dok;
      bus.cpu_error_i         = err;
   endtask

   function automatic vec_t mk(input logic [3:0] rv, input logic [127:0] rpc,
                               input logic fl, input logic intr, input logic al,
                               input logic aok, input logic dok,
                               input logic req, input logic [31:0] addr, input logic val,
                               input logic [1:0] mask, input logic ei, input logic ea);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.fl = fl; v.intr = intr; v.al = al; v.aok = aok; v.dok = dok;
      v.exp = '{req: req, addr: addr, valid: val, mask: mask, intr: ei, adef: ea};
      return v;
   endfunction

   task automatic drain();
      int guard;
      guard = 0;
      while (m_outst > 0 && guard < 20) begin
         drive('0, '0, 0, 0, 0, 0, 1);
         step();
         guard++;
      end
      check("drain_done", 64'(m_outst), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Directed table starting from reset release; rows are consecutive cycles.
      tbl[0]  = mk(4'b0000, '0, 0,0,1,1,0, 1, 32'h1c000000, 1, 2'b11, 0, 0);
      tbl[1]  = mk(4'b0000, '0, 0,0,1,1,0, 1, 32'h1c000008, 1, 2'b11, 0, 0);
      tbl[2]  = mk(4'b0000, '0, 0,0,1,1,1, 1, 32'h1c000010, 1, 2'b11, 0, 0);
      tbl[3]  = mk(4'b1100, {32'h1c000200, 32'h1c000104, 64'h0},
                             0,0,1,1,1, 1, 32'h1c000104, 1, 2'b10, 0, 0);
      tbl[4]  = mk(4'b0000, '0, 0,0,1,1,1, 1, 32'h1c000108, 1, 2'b11, 0, 0);
      tbl[5]  = mk(4'b0001, {96'h0, 32'h1c000300},
                             1,0,1,1,0, 0, 32'h1c000300, 0, 2'b11, 0, 0);
      tbl[6]  = mk(4'b0000, '0, 0,0,0,1,0, 0, 32'h1c000300, 0, 2'b11, 0, 0);
      tbl[7]  = mk(4'b0000, '0, 0,0,1,0,0, 1, 32'h1c000300, 0, 2'b11, 0, 0);
      tbl[8]  = mk(4'b0000, '0, 0,0,1,1,1, 1, 32'h1c000300, 1, 2'b11, 0, 0);
      tbl[9]  = mk(4'b0000, '0, 0,1,1,1,0, 0, 32'h1c000308, 1, 2'b11, 1, 0);
      tbl[10] = mk(4'b0000, '0, 0,0,1,1,0, 0, 32'h1c000308, 0, 2'b11, 0, 0);
      tbl[11] = mk(4'b0010, {64'h0, 32'h1c000004, 32'h0},
                             0,0,1,1,0, 1, 32'h1c000004, 1, 2'b10, 0, 0);
      tbl[12] = mk(4'b0000, '0, 0,0,1,1,0, 1, 32'h1c000008, 1, 2'b11, 0, 0);
      tbl[13] = mk(4'b0000, '0, 0,0,1,1,0, 0, 32'h1c000010, 0, 2'b11, 0, 0);
      tbl[14] = mk(4'b0000, '0, 0,0,1,1,1, 0, 32'h1c000010, 0, 2'b11, 0, 0);
      tbl[15] = mk(4'b0000, '0, 0,0,1,1,0, 1, 32'h1c000010, 1, 2'b11, 0, 0);

      // Reset state, with inputs that would otherwise request.
      model_reset();
      drive('0, '0, 0, 0, 1, 1, 0);
      settle();
      check("reset_req",   bus.inst_sram_req_o,  1'b0);
      check("reset_valid", bus.to_next_valid_o,  1'b0);
      check("reset_addr",  bus.inst_sram_addr_o, RESET_PC);
      advance();
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].rv, tbl[i].rpc, tbl[i].fl, tbl[i].intr, tbl[i].al, tbl[i].aok, tbl[i].dok);
         settle();
         check($sformatf("tbl%0d_req", i),   bus.inst_sram_req_o,  tbl[i].exp.req);
         check($sformatf("tbl%0d_addr", i),  bus.inst_sram_addr_o, tbl[i].exp.addr);
         check($sformatf("tbl%0d_valid", i), bus.to_next_valid_o,  tbl[i].exp.valid);
         check($sformatf("tbl%0d_mask", i),  bus.to_next_mask_o,   tbl[i].exp.mask);
         check($sformatf("tbl%0d_int", i),   bus.to_next_int_o,    tbl[i].exp.intr);
         check($sformatf("tbl%0d_adef", i),  bus.to_next_adef_o,   tbl[i].exp.adef);
         advance();
      end

      // Reset asserted mid-cycle while requests are in flight.
      drive('0, '0, 0, 0, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #2;
      check_model();
      check("midrst_req",  bus.inst_sram_req_o,  1'b0);
      check("midrst_addr", bus.inst_sram_addr_o, RESET_PC);
      check("midrst_mask", bus.to_next_mask_o,   2'b00);
      advance();
      rst_n = 1'b1;

      // Outstanding limit: four accepted requests, then req drops until a return.
      for (int i = 0; i < 4; i++) begin
         drive('0, '0, 0, 0, 1, 1, 0);
         step();
      end
      drive('0, '0, 0, 0, 1, 1, 0);
      settle();
      check("outst_full_req", bus.inst_sram_req_o, 1'b0);
      advance();
      drive('0, '0, 0, 0, 1, 1, 1);
      settle();
      check("outst_dok_req", bus.inst_sram_req_o, 1'b0);
      advance();
      drive('0, '0, 0, 0, 1, 1, 0);
      settle();
      check("outst_reassert_req", bus.inst_sram_req_o, 1'b1);
      advance();
      drain();

      // Redirect arriving while IF stalls is held in pc_r.
      drive(4'b0001, {96'h0, 32'h1c000400}, 0, 0, 0, 1, 0);
      settle();
      check("stall_redir_req", bus.inst_sram_req_o, 1'b0);
      advance();
      for (int i = 0; i < 2; i++) begin
         drive('0, '0, 0, 0, 0, 1, 0);
         settle();
         check("stall_idle_req", bus.inst_sram_req_o, 1'b0);
         advance();
      end
      drive('0, '0, 0, 0, 1, 1, 0);
      settle();
      check("held_redir_req",  bus.inst_sram_req_o,  1'b1);
      check("held_redir_addr", bus.inst_sram_addr_o, 32'h1c000400);
      advance();
      drain();

      // Misaligned redirect: adef group, then idle in EXC_HOLD until a redirect.
      drive(4'b0001, {96'h0, 32'h1c000102}, 0, 0, 1, 1, 0);
      settle();
      check("adef_valid", bus.to_next_valid_o, 1'b1);
      check("adef_flag",  bus.to_next_adef_o,  1'b1);
      check("adef_req",   bus.inst_sram_req_o, 1'b0);
      advance();
      for (int i = 0; i < 3; i++) begin
         drive('0, '0, 0, 0, 1, 1, 0);
         settle();
         check("hold_req",   bus.inst_sram_req_o, 1'b0);
         check("hold_valid", bus.to_next_valid_o, 1'b0);
         advance();
      end
      drive(4'b0001, {96'h0, 32'h1c000000}, 0, 0, 1, 1, 0);
      settle();
      check("unhold_req",   bus.inst_sram_req_o,  1'b1);
      check("unhold_valid", bus.to_next_valid_o,  1'b1);
      check("unhold_addr",  bus.inst_sram_addr_o, 32'h1c000000);
      advance();
      drain();

      // Random traffic against the model, with occasional resets.
      for (int n = 0; n < 500; n++) begin
         logic [NRED-1:0]    rv;
         logic [NRED*32-1:0] rpc;
         logic               dok;
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(199) == 0) rst_n = 1'b0;
         rv = ($urandom_range(3) == 0) ? NRED'($urandom) : '0;
         for (int k = 0; k < NRED; k++) begin
            logic [31:0] p;
            p = 32'h1c000000 | ($urandom & 32'h0000_fffc);
            if ($urandom_range(9) == 0) p[1:0] = 2'($urandom_range(3));
            rpc[k*32 +: 32] = p;
         end
         dok = (m_outst > 0) && ($urandom_range(9) < 4);
         drive(rv, rpc, $urandom_range(9) == 0, $urandom_range(19) == 0,
               $urandom_range(9) < 8, $urandom_range(9) < 7, dok);
         step();
      end
      if (!rst_n) begin
         drive('0, '0, 0, 0, 0, 0, 0);
         step();
         rst_n = 1'b1;
      end

      // cpu_error pulse: permanent halt until reset.
      drive('0, '0, 0, 0, 1, 1, 0, 1'b1);
      settle();
      check("err_req",   bus.inst_sram_req_o, 1'b0);
      check("err_valid", bus.to_next_valid_o, 1'b0);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(4'b0001, {96'h0, 32'h1c000000}, 0, 0, 1, 1, 0);
         settle();
         check("halt_req",   bus.inst_sram_req_o, 1'b0);
         check("halt_valid", bus.to_next_valid_o, 1'b0);
         advance();
      end
      drive('0, '0, 0, 0, 1, 1, 0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive('0, '0, 0, 0, 1, 1, 0);
      settle();
      check("after_rst_req",  bus.inst_sram_req_o,  1'b1);
      check("after_rst_addr", bus.inst_sram_addr_o, RESET_PC);
      advance();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/preif_fetch_pcgen.md
# preif_fetch_pcgen

Parametrised pre-fetch (PreIF) stage. It selects the next fetch PC from prioritised redirect sources or the sequential group address, and issues the instruction-SRAM address request. It holds any un-accepted target in an internal PC register, limits outstanding fetches, and emits FETCH_N-wide fetch groups with a lane mask to the IF stage. It sits between the redirect producers (CSR, ID, IFT, IF) and the IF stage / instruction SRAM interface.

## Interface
Parameters:
- PC_W, 32, PC width.
- FETCH_N, 2, instructions per fetch group; power of two, 1..8.
- NRED, 4, number of redirect sources; index 0 has highest priority.
- MAX_OUTST, 4, maximum requests accepted but not yet returned; 1..15.
- RESET_PC, 32'h1c000000, first fetch address.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- redirect_valid_i  in  NRED  per-source redirect request.
- redirect_pc_i  in  NRED*PC_W  per-source target; source k occupies bits [k*PC_W +: PC_W].
- flush_i  in  1  pipeline flush; suppresses the request this cycle.
- cpu_error_i  in  1  fatal error; sticky halt.
- interrupt_en_i  in  1  tag the next group with an interrupt.
- next_allowin_i  in  1  IF stage can accept.
- inst_sram_req_o  out  1  address request.
- inst_sram_addr_o  out  PC_W  request address, equal to the selected PC (not aligned).
- inst_sram_addr_ok_i  in  1  address accepted.
- inst_sram_data_ok_i  in  1  one outstanding request returned.
- to_next_valid_o  out  1  group handed to IF.
- to_next_pc_o  out  PC_W  selected PC.
- to_next_mask_o  out  FETCH_N  valid lanes.
- to_next_int_o  out  1  interrupt tag.
- to_next_adef_o  out  1  fetch address error.

## Operation
- Internal state:
  - pc_r: next PC to fetch.
  - outst_r: outstanding count, $clog2(MAX_OUTST+1) bits wide.
  - st_r: one of RUN, EXC_HOLD, HALT.
- Selection:
  - redir = |redirect_valid_i.
  - sel_pc = the PC of the lowest-index valid redirect source; otherwise pc_r.
  - A redirect overrides pc_r in the same cycle it arrives.
- Exceptions (combinational):
  - adef = sel_pc[1:0] != 0.
  - exc = adef | interrupt_en_i.
- Request:
  - inst_sram_req_o = rst_n & (st_r==RUN | redir) & st_r!=HALT & ~cpu_error_i & next_allowin_i & ~flush_i & ~exc & (outst_r < MAX_OUTST).
- Handshake to IF:
  - fire = (inst_sram_req_o & inst_sram_addr_ok_i) | (exc & ~flush_i & next_allowin_i & st_r!=HALT & ~cpu_error_i & (st_r==RUN | redir)).
  - to_next_valid_o = fire.
- Lane mask:
  - off = sel_pc[$clog2(FETCH_N)+1:2].
  - Lanes off..FETCH_N-1 are set; all other lanes are clear.
  - When FETCH_N=1 the mask is 1'b1.
- pc_r update:
  - On fire with no exception: pc_r <= (sel_pc & ~(FETCH_N*4-1)) + FETCH_N*4, with PC_W-bit wrap-around.
  - On fire with an exception: pc_r <= sel_pc.
  - Without fire: pc_r <= sel_pc. This latches a pending redirect so it is not lost while IF stalls, addr_ok is low, or flush is active.
- State machine:
  - RUN -> EXC_HOLD on fire with exc. No further requests are made until a redirect arrives.
  - EXC_HOLD -> RUN on redir. The redirect is serviced in that same cycle.
  - Any state -> HALT when cpu_error_i is high. HALT is exited only by reset.
- outst_r:
  - +1 on req & addr_ok.
  - -1 on data_ok.
  - Unchanged when both occur in the same cycle.
  - data_ok while outst_r==0 is ignored and is a bench assertion failure.
  - Flush does not alter outst_r.
- Interrupt tag: to_next_int_o = interrupt_en_i & fire. When both adef and interrupt hold, both flags are set.

## Timing
- Reset values: pc_r=RESET_PC, outst_r=0, st_r=RUN.
- All outputs are 0 while rst_n is low, except inst_sram_addr_o and to_next_pc_o, which show RESET_PC.
- Redirect-to-request latency is 0 cycles: the request is combinational from redirect_valid_i.
- inst_sram_addr_o and inst_sram_req_o stay stable while req is high and addr_ok is low, provided no higher-priority redirect appears.
- A new redirect during a pending request replaces the address. The IF stage accepts this as a cancelled request.
- At most one group is emitted per cycle. Back-to-back groups are emitted each cycle when addr_ok stays high and outst_r < MAX_OUTST.
- If reset asserts mid-operation, all state returns to reset values immediately. Returns that arrive after reset are ignored.

## Test plan
- Reset release, FETCH_N=2, addr_ok=1 constant -> requests at 1c000000, 1c000008, 1c000010 on consecutive cycles; every mask = 2'b11.
- Redirect source 2 = 1c000104 together with source 3 = 1c000200 -> request addr 1c000104 with mask 2'b10; the next request is 1c000108.
- Redirect arrives while next_allowin_i=0 for 3 cycles -> no req. When allowin rises, req addr = the redirect target, with no redirect_valid_i present.
- addr_ok on 4 consecutive cycles with MAX_OUTST=4 and no data_ok -> req drops on the 5th cycle. One data_ok pulse -> req reasserts on the next cycle.
- Redirect to 1c000102 -> valid=1, adef=1, req=0. The block then stays idle in EXC_HOLD until a redirect to 1c000000, which fetches in the same cycle.
- cpu_error_i pulses for 1 cycle -> req and valid stay 0 permanently; a later redirect is ignored until rst_n toggles.
